// File: rtl/key_bounce_gen_pkg.sv
// Shared types, LFSR constants and timing helpers for the key bounce generator.
package key_bounce_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        RELEASE_BOUNCE,
        SETTLE
    } kb_state_e;

    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7,5,4,3 on a left shift
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Number of clock cycles inside the debounce window.
    function automatic int glitch_cycles(input int clk_mhz, input int glitch_ns);
        return clk_mhz * glitch_ns / 1000;
    endfunction

    // Counter width able to hold a full 16-bit hold count and GLITCH_CYCLES+1.
    function automatic int cnt_width(input int glitch);
        int need;
        need = $clog2(glitch + 2);
        return (need > 16) ? need : 16;
    endfunction

endpackage

// File: rtl/key_bounce_gen_if.sv
// Request/status bundle between a press requester and the bounce generator.
interface key_bounce_gen_if;
    logic        press_stb_i;
    logic [15:0] hold_cycles_i;
    logic        key_o;
    logic        busy_o;
    logic        done_stb_o;

    modport master (
        output press_stb_i, hold_cycles_i,
        input  key_o, busy_o, done_stb_o
    );

    modport slave (
        input  press_stb_i, hold_cycles_i,
        output key_o, busy_o, done_stb_o
    );
endinterface

// File: rtl/key_bounce_gen_lfsr8.sv
// 8-bit Fibonacci LFSR; steps once per adv, seeded so it never sits at zero.
module lfsr8
    import key_bounce_pkg::*;
(
    input  logic       clk_i,
    input  logic       srst_i,
    input  logic       adv,
    output logic [7:0] value_o
);
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next value: shift left, feed parity of tapped bits into bit 0
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // State register, reset reloads the seed
    always_ff @(posedge clk_i) begin
        if (srst_i) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign value_o = lfsr_q;
endmodule

// File: rtl/key_bounce_gen.sv
// Emulates a bouncing mechanical key: bounce, hold, bounce, settle per request.
module key_bounce_gen
    import key_bounce_pkg::*;
#(
    parameter int   CLK_FREQ_MHZ   = 10,
    parameter int   GLITCH_TIME_NS = 500,
    parameter int   BOUNCE_PULSES  = 3,
    parameter logic PRESSED_LEVEL  = 1'b0
) (
    input  logic clk_i,
    input  logic srst_i,
    key_bounce_gen_if.slave bus
);
    localparam int   GLITCH_CYCLES  = glitch_cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);
    localparam int   CW             = cnt_width(GLITCH_CYCLES);
    localparam int   SW             = 5;
    localparam logic RELEASED_LEVEL = ~PRESSED_LEVEL;

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t          MIN_HOLD    = cnt_t'(GLITCH_CYCLES + 1);
    localparam cnt_t          SETTLE_LAST = cnt_t'(GLITCH_CYCLES);
    localparam logic [SW-1:0] LAST_SEG    = SW'(2 * BOUNCE_PULSES - 1);

    if (GLITCH_CYCLES < 2) begin : g_bad_glitch
        $error("GLITCH_CYCLES must be at least 2");
    end
    if (BOUNCE_PULSES < 1 || BOUNCE_PULSES > 15) begin : g_bad_pulses
        $error("BOUNCE_PULSES must be within 1..15");
    end

    kb_state_e     state_q, state_d;
    cnt_t          cnt_q, cnt_d;
    cnt_t          hold_q, hold_d;
    logic [SW-1:0] seg_q, seg_d;
    logic          key_q, key_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          adv;
    logic [7:0]    lfsr_val;
    cnt_t          seg_len_m1;
    cnt_t          hold_ext;

    lfsr8 u_lfsr (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .adv     (adv),
        .value_o (lfsr_val)
    );

    // Segment length minus one: 0..GLITCH_CYCLES-2, so every bounce is below the window
    assign seg_len_m1 = cnt_t'(int'(lfsr_val) % (GLITCH_CYCLES - 1));
    assign hold_ext   = cnt_t'(bus.hold_cycles_i);

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        seg_d   = seg_q;
        key_d   = key_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                key_d  = RELEASED_LEVEL;
                busy_d = 1'b0;
                if (bus.press_stb_i) begin
                    state_d = PRESS_BOUNCE;
                    hold_d  = (hold_ext > MIN_HOLD) ? hold_ext : MIN_HOLD;
                    seg_d   = '0;
                    cnt_d   = seg_len_m1;
                    adv     = 1'b1;
                    key_d   = PRESSED_LEVEL;
                    busy_d  = 1'b1;
                end
            end
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end else if (seg_q == LAST_SEG) begin
                    if (state_q == PRESS_BOUNCE) begin
                        state_d = HOLD;
                        cnt_d   = hold_q - cnt_t'(1);
                        key_d   = PRESSED_LEVEL;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LAST;
                        key_d   = RELEASED_LEVEL;
                    end
                end else begin
                    seg_d = seg_q + SW'(1);
                    cnt_d = seg_len_m1;
                    adv   = 1'b1;
                    key_d = ~key_q;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end else begin
                    state_d = RELEASE_BOUNCE;
                    seg_d   = '0;
                    cnt_d   = seg_len_m1;
                    adv     = 1'b1;
                    key_d   = RELEASED_LEVEL;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - cnt_t'(1);
                    done_d = (cnt_q == cnt_t'(1));
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset wins over any request
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            seg_q   <= '0;
            key_q   <= RELEASED_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            seg_q   <= seg_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.key_o      = key_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_stb_o = done_q;
endmodule
